// File: rtl/boot_strap_pkg.sv
// Shared types for the boot strap controller: boot mode encoding, FSM states
// and bit positions inside the 4-bit strap vector {clk_byp, debug, mode[1:0]}.
package boot_strap_pkg;

  typedef enum logic [1:0] {
    BOOT_ROM  = 2'b00,
    BOOT_SPI  = 2'b01,
    BOOT_UART = 2'b10,
    BOOT_JTAG = 2'b11
  } bootmode_e;

  typedef enum logic [2:0] {
    ST_SETTLE = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_LOCKED = 3'd2,
    ST_BOOT   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int STRAP_W       = 4;
  localparam int STRAP_MODE_LO = 0;
  localparam int STRAP_MODE_HI = 1;
  localparam int STRAP_DEBUG   = 2;
  localparam int STRAP_BYP     = 3;

endpackage

// File: rtl/boot_strap_ctrl_sync.sv
// Two-stage synchronizer for asynchronous strap pads; flops clear on reset.
module strap_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/boot_strap_ctrl.sv
// Boot strap sampler: settle, debounce and latch the strap pads, then issue one boot request.
// Defining BOOT_STRAP_SW_OVERRIDE_EN adds ovr_we_i/ovr_data_i to rewrite the latched straps.
module boot_strap_ctrl
  import boot_strap_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int STABLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [1:0]   boot_mode_pad_i,
  input  logic         debug_en_pad_i,
  input  logic         clk_byp_en_pad_i,
`ifdef BOOT_STRAP_SW_OVERRIDE_EN
  input  logic         ovr_we_i,
  input  logic [3:0]   ovr_data_i,
`endif
  output logic         pad_ie_o,
  output bootmode_e    boot_mode_o,
  output logic         debug_en_o,
  output logic         clk_byp_en_o,
  output logic         strap_valid_o,
  output logic         strap_err_o,
  output logic         boot_req_o,
  input  logic         boot_ack_i
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int STABLE_W = $clog2(STABLE_CYCLES + 1);
  localparam int SAMPLE_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e               state_q, state_d;
  logic [SETTLE_W-1:0]  settle_q, settle_d;
  logic [STABLE_W-1:0]  stable_q, stable_d;
  logic [SAMPLE_W-1:0]  sample_q, sample_d;
  logic [STRAP_W-1:0]   sync_vec, prev_q;
  logic [STRAP_W-1:0]   latch_q, latch_d;
  logic                 err_q, err_d;
  logic                 match, stable_done, timed_out;

  strap_sync #(.WIDTH(STRAP_W)) u_sync (
    .clk (clk_i),
    .rst (rst_i),
    .d   ({clk_byp_en_pad_i, debug_en_pad_i, boot_mode_pad_i}),
    .q   (sync_vec)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_SETTLE;
      settle_q <= '0;
      stable_q <= '0;
      sample_q <= '0;
      prev_q   <= '0;
      latch_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      stable_q <= stable_d;
      sample_q <= sample_d;
      prev_q   <= sync_vec;
      latch_q  <= latch_d;
      err_q    <= err_d;
    end
  end

  // The first SAMPLE cycle has no in-window predecessor, so it only seeds the comparison.
  assign match       = (sample_q != '0) && (sync_vec == prev_q);
  assign stable_done = match && (stable_q == STABLE_W'(STABLE_CYCLES - 1));
  assign timed_out   = (sample_q == SAMPLE_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    stable_d = stable_q;
    sample_d = sample_q;
    latch_d  = latch_q;
    err_d    = err_q;

    case (state_q)
      ST_SETTLE: begin
        if (settle_q != SETTLE_W'(SETTLE_CYCLES)) settle_d = settle_q + 1'b1;
        if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (sample_q != SAMPLE_W'(TIMEOUT_CYCLES)) sample_d = sample_q + 1'b1;
        if (match) begin
          if (stable_q != STABLE_W'(STABLE_CYCLES)) stable_d = stable_q + 1'b1;
        end else begin
          stable_d = '0;
        end
        if (stable_done || timed_out) begin
          latch_d = sync_vec;
          err_d   = !stable_done;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: state_d = ST_BOOT;
      ST_BOOT:   if (boot_ack_i) state_d = ST_DONE;
      ST_DONE:   state_d = ST_DONE;
      default:   state_d = ST_SETTLE;
    endcase

`ifdef BOOT_STRAP_SW_OVERRIDE_EN
    if (ovr_we_i && (state_q == ST_LOCKED || state_q == ST_BOOT)) begin
      latch_d = ovr_data_i;
      err_d   = 1'b0;
    end
`endif
  end

  assign pad_ie_o      = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign strap_valid_o = (state_q == ST_LOCKED) || (state_q == ST_BOOT) || (state_q == ST_DONE);
  assign boot_req_o    = (state_q == ST_BOOT);
  assign boot_mode_o   = bootmode_e'(latch_q[STRAP_MODE_HI:STRAP_MODE_LO]);
  assign debug_en_o    = latch_q[STRAP_DEBUG];
  assign clk_byp_en_o  = latch_q[STRAP_BYP];
  assign strap_err_o   = err_q;

endmodule

// File: tb/tb_boot_strap_ctrl.sv
// Randomized bench for boot_strap_ctrl against a window-based reference of the strap sequence.
module tb_boot_strap_ctrl;

  localparam int SETTLE  = 16;
  localparam int STABLE  = 8;
  localparam int TIMEOUT = 256;
  localparam int MAXC    = 400;

  logic       clk, rst;
  logic [3:0] pads;
  logic       ack;
  logic       pad_ie, dbg_o, byp_o, valid_o, err_o, req_o;
  logic [1:0] mode_o;
`ifdef BOOT_STRAP_SW_OVERRIDE_EN
  logic       ovr_we;
  logic [3:0] ovr_dat;
  int         ovr_c1, ovr_c2;
  logic [3:0] ovr_v;
`endif

  boot_strap_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .boot_mode_pad_i (pads[1:0]),
    .debug_en_pad_i  (pads[2]),
    .clk_byp_en_pad_i(pads[3]),
`ifdef BOOT_STRAP_SW_OVERRIDE_EN
    .ovr_we_i        (ovr_we),
    .ovr_data_i      (ovr_dat),
`endif
    .pad_ie_o        (pad_ie),
    .boot_mode_o     (mode_o),
    .debug_en_o      (dbg_o),
    .clk_byp_en_o    (byp_o),
    .strap_valid_o   (valid_o),
    .strap_err_o     (err_o),
    .boot_req_o      (req_o),
    .boot_ack_i      (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         nvec, nmis;
  logic [3:0] pad_seq [MAXC];
  logic       ack_seq [MAXC];
  int         lock_c, done_c, rise_c, req_n;
  logic [3:0] lock_v;
  logic       lock_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pad value applied during cycle k reaches the synchronizer output two cycles later.
  function automatic logic [3:0] sync_at(input int k);
    return (k >= 2) ? pad_seq[k-2] : 4'h0;
  endfunction

  // Lock on the first sample window of STABLE+1 identical values, else at the timeout cycle.
  function automatic void model_lock();
    logic same;
    lock_c = -1;
    for (int k = SETTLE + STABLE; k <= SETTLE + TIMEOUT - 1; k++) begin
      if (lock_c < 0) begin
        same = 1'b1;
        for (int j = k - STABLE; j < k; j++)
          if (sync_at(j) != sync_at(k)) same = 1'b0;
        if (same) begin lock_c = k; lock_e = 1'b0; end
      end
    end
    if (lock_c < 0) begin lock_c = SETTLE + TIMEOUT - 1; lock_e = 1'b1; end
    lock_v = sync_at(lock_c);
  endfunction

  function automatic void model_done();
    done_c = MAXC;
    for (int k = MAXC - 1; k >= lock_c + 2; k--)
      if (ack_seq[k]) done_c = k;
  endfunction

  function automatic void fill_const(input logic [3:0] v);
    for (int k = 0; k < MAXC; k++) begin pad_seq[k] = v; ack_seq[k] = 1'b0; end
  endfunction

  function automatic void fill_rand();
    int k, h;
    logic [3:0] v;
    k = 0;
    while (k < MAXC) begin
      v = 4'($urandom);
      h = ($urandom_range(0, 2) == 0) ? $urandom_range(9, 20) : $urandom_range(1, 6);
      for (int j = 0; j < h; j++) if (k + j < MAXC) pad_seq[k+j] = v;
      k += h;
    end
    for (int j = 0; j < MAXC; j++) ack_seq[j] = ($urandom_range(0, 4) == 0);
  endfunction

  task automatic run_scen(input string name, input int rst_at);
    int len;
    logic [3:0] ev;
    logic       ee;
    len = (rst_at >= 0) ? rst_at + 1 : done_c + 6;
    rise_c = -1;
    req_n  = 0;
    rst = 1'b1;
    ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < len; c++) begin
      if (c > 0) @(negedge clk);
      if (valid_o === 1'b1 && rise_c < 0) rise_c = c;
      if (req_o === 1'b1) req_n++;
      ev = (c > lock_c) ? lock_v : 4'h0;
      ee = (c > lock_c) ? lock_e : 1'b0;
`ifdef BOOT_STRAP_SW_OVERRIDE_EN
      if (ovr_c1 > lock_c && ovr_c1 <= done_c && c > ovr_c1) begin ev = ovr_v; ee = 1'b0; end
`endif
      chk($sformatf("%s_ie@%0d", name, c), 32'(pad_ie), 32'(c <= lock_c));
      chk($sformatf("%s_valid@%0d", name, c), 32'(valid_o), 32'(c > lock_c));
      chk($sformatf("%s_err@%0d", name, c), 32'(err_o), 32'(ee));
      chk($sformatf("%s_vec@%0d", name, c), 32'({byp_o, dbg_o, mode_o}), 32'(ev));
      chk($sformatf("%s_req@%0d", name, c), 32'(req_o), 32'(c >= lock_c + 2 && c <= done_c));
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        chk($sformatf("%s_rst_out", name), 32'({pad_ie, valid_o, err_o, req_o, byp_o, dbg_o, mode_o}),
            32'(8'b1000_0000));
        return;
      end
      pads = pad_seq[c];
      ack  = ack_seq[c];
`ifdef BOOT_STRAP_SW_OVERRIDE_EN
      ovr_we  = (c == ovr_c1) || (c == ovr_c2);
      ovr_dat = ovr_v;
`endif
    end
  endtask

  initial begin
    nvec = 0;
    nmis = 0;
    rst  = 1'b1;
    pads = 4'h0;
    ack  = 1'b0;
`ifdef BOOT_STRAP_SW_OVERRIDE_EN
    ovr_we = 1'b0; ovr_dat = 4'h0; ovr_c1 = -1; ovr_c2 = -1; ovr_v = 4'h0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_out", 32'({pad_ie, valid_o, err_o, req_o, byp_o, dbg_o, mode_o}), 32'(8'b1000_0000));

    // Constant straps: mode 01, debug 1, bypass 0.
    fill_const(4'b0101);
    model_lock();
    for (int k = lock_c + 4; k < MAXC; k++) ack_seq[k] = 1'b1;
    model_done();
    run_scen("const", -1);
    chk("const_rise_window", 32'(rise_c >= 25 && rise_c <= 27), 32'd1);

    // Pads toggling every 4 cycles never settle, forcing the timeout latch.
    for (int k = 0; k < MAXC; k++) begin
      pad_seq[k] = ((k / 4) % 2 == 0) ? 4'b0110 : 4'b1001;
      ack_seq[k] = (k > 280);
    end
    model_lock();
    model_done();
    run_scen("toggle", -1);

    // One-cycle debug glitch landing in the sampler at stable count 5.
    fill_const(4'b0011);
    pad_seq[SETTLE + 4] = 4'b0111;
    model_lock();
    for (int k = lock_c + 3; k < MAXC; k++) ack_seq[k] = 1'b1;
    model_done();
    run_scen("glitch", -1);

    // Early ack pulse is ignored; ack held low for 10 BOOT cycles.
    fill_const(4'b1010);
    ack_seq[SETTLE + 3] = 1'b1;
    model_lock();
    for (int k = lock_c + 12; k < MAXC; k++) ack_seq[k] = 1'b1;
    model_done();
    run_scen("ack", -1);
    chk("ack_req_len", 32'(req_n), 32'd11);

    // Reset mid-BOOT, then a fresh sequence with mode 10.
    fill_const(4'b0101);
    model_lock();
    model_done();
    run_scen("midrst", lock_c + 5);
    fill_const(4'b0010);
    model_lock();
    for (int k = lock_c + 6; k < MAXC; k++) ack_seq[k] = 1'b1;
    model_done();
    run_scen("after_rst", -1);

`ifdef BOOT_STRAP_SW_OVERRIDE_EN
    fill_const(4'b0101);
    model_lock();
    ack_seq[lock_c + 6] = 1'b1;
    model_done();
    ovr_v  = 4'b1011;
    ovr_c1 = lock_c + 3;
    ovr_c2 = lock_c + 9;
    run_scen("override", -1);
    chk("override_vec", 32'({byp_o, dbg_o, mode_o}), 32'(4'b1011));
    ovr_c1 = -1;
    ovr_c2 = -1;
    ovr_we = 1'b0;
`endif

    for (int r = 0; r < 8; r++) begin
      fill_rand();
      model_lock();
      ack_seq[lock_c + 22] = 1'b1;
      model_done();
      run_scen($sformatf("rand%0d", r),
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, done_c) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
